// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants and helpers for the filter-datapath adders.
//   DEFAULT_WIDTH   default operand/sum width of full_adder
//   signed_ovf()    two's-complement overflow from operand and sum sign bits,
//                   shared so other datapath blocks flag overflow the same way
package full_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Overflow happens only when both operands share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit full adder, one link of the ripple-carry chain.
// Ports:
//   a, b  operand bits
//   cin   carry into this bit
//   s     sum bit (combinational)
//   cout  carry out of this bit (combinational)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with carry-in, registered outputs.
// {Cout,S} = A + B + Cin (modulo 2^(WIDTH+1)), latency one cycle, one sum per cycle.
// Optional feature macro: FULL_ADDER_OVF_EN adds the registered signed-overflow flag V.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears all outputs)
//   in_valid   A/B/Cin valid this cycle
//   A, B       WIDTH-bit operands (unsigned or two's complement)
//   Cin        carry-in
//   S          registered sum
//   Cout       registered carry-out of bit WIDTH-1
//   out_valid  S/Cout/V hold a result sampled on the previous edge
//   V          registered signed overflow (FULL_ADDER_OVF_EN only)
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH  // must be >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_c;

  assign carry_c[0] = Cin;

  // Ripple chain: carry_c[i+1] is the carry out of bit i, carry_c[WIDTH] is Cout.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry_c[i]),
      .s    (sum_c[i]),
      .cout (carry_c[i+1])
    );
  end

  // Output register: load on in_valid, hold otherwise; out_valid marks fresh results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum_c;
        Cout <= carry_c[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  logic ovf_c;

  // Equivalent to carry_c[WIDTH] ^ carry_c[WIDTH-1]; sign-bit form matches other blocks.
  assign ovf_c = signed_ovf(A[WIDTH-1], B[WIDTH-1], sum_c[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      V <= 1'b0;
    end else if (in_valid) begin
      V <= ovf_c;
    end
  end
`endif

endmodule : full_adder

// File: tb/tb_full_adder.sv
// tb_full_adder: directed table, reset/hold sequences and random vectors for full_adder.
module tb_full_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] s;
  logic         cout;
  logic         out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic         v;
`endif

  int checks = 0;
  int passed = 0;

  // Reference state: what the outputs should show after the latest edge.
  logic [W-1:0] m_s    = '0;
  logic         m_cout = 1'b0;
  logic         m_v    = 1'b0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .S         (s),
    .Cout      (cout),
    .out_valid (out_valid)
`ifdef FULL_ADDER_OVF_EN
    ,
    .V         (v)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         v;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string name, input logic [W-1:0] es, input logic ec,
                            input logic ev, input logic evld);
    check({name, ".S"}, 32'(s), 32'(es));
    check({name, ".Cout"}, 32'(cout), 32'(ec));
    check({name, ".out_valid"}, 32'(out_valid), 32'(evld));
`ifdef FULL_ADDER_OVF_EN
    check({name, ".V"}, 32'(v), 32'(ev));
`else
    if (ev !== ev) $display("unreachable");
`endif
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return (W+1)'(t);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    int t;
    t = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (t > 32767) || (t < -32768);
  endfunction

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic vld, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c);
    @(negedge clk);
    in_valid = vld;
    a = x;
    b = y;
    cin = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W:0] r;

    vecs[0] = '{16'h0180, 16'h0340, 1'b0, 16'h04C0, 1'b0, 1'b0};
    vecs[1] = '{16'h0180, 16'hFCC0, 1'b0, 16'hFE40, 1'b0, 1'b0};
    vecs[2] = '{16'hFE80, 16'h0340, 1'b0, 16'h01C0, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    // Reset state with clock running.
    #12;
    check_outs("reset", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      check_outs($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].v, 1'b1);
    end

    // Hold: in_valid low, operands change, outputs keep the last result.
    step(1'b0, 16'h1234, 16'h4321, 1'b1);
    check_outs("hold0", vecs[7].s, vecs[7].cout, vecs[7].v, 1'b0);
    step(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    check_outs("hold1", vecs[7].s, vecs[7].cout, vecs[7].v, 1'b0);

    // Asynchronous reset mid-stream, between edges.
    step(1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
    check_outs("pre_rst", 16'hFFFF, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    check_outs("rst_hold", '0, 1'b0, 1'b0, 1'b0);

    // First edge after release samples normally.
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    a = 16'h0001;
    b = 16'h0002;
    cin = 1'b0;
    @(posedge clk);
    #1;
    check_outs("post_rst", 16'h0003, 1'b0, 1'b0, 1'b1);
    m_s = 16'h0003;
    m_cout = 1'b0;
    m_v = 1'b0;

    // Random stream against the integer reference.
    for (int i = 0; i < 300; i++) begin
      logic         vld;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         c;
      vld = ($urandom_range(0, 3) != 0);
      x   = W'($urandom);
      y   = W'($urandom);
      c   = 1'($urandom);
      step(vld, x, y, c);
      if (vld) begin
        r      = ref_sum(x, y, c);
        m_s    = r[W-1:0];
        m_cout = r[W];
        m_v    = ref_ovf(x, y, c);
      end
      check_outs($sformatf("rand%0d", i), m_s, m_cout, m_v, vld);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_full_adder
